// File: rtl/lfsr_seq_pkg.sv
// Shared types and register map for the LFSR step sequencer.
package lfsr_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_POLY,
        WR_SEED,
        STEP,
        SETTLE,
        OUTPUT,
        STOP,
        DONE
    } state_t;

    localparam logic [15:0] POLY_REG = 16'h0010;
    localparam logic [15:0] LFSR_REG = 16'h0012;
    localparam logic [15:0] CTRL_REG = 16'h0014;

    localparam logic [1:0] CTRL_STEP = 2'b01;
    localparam logic [1:0] CTRL_STOP = 2'b00;

endpackage

// File: rtl/lfsr_step_sequencer.sv
// Loads poly/seed into the LFSR block, single-steps it N times and streams each Q.
// Bus and status outputs are registered from the next state, so they are Moore in state.
module lfsr_step_sequencer
    import lfsr_seq_pkg::*;
#(
    parameter int n  = 8,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [n-1:0]  cmd_poly,
    input  logic [n-1:0]  cmd_seed,
    input  logic [CW-1:0] cmd_count,
    input  logic          abort,
    output logic          W,
    output logic [15:0]   A,
    output logic [n-1:0]  D,
    input  logic [n-1:0]  Q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [n-1:0]  out_data,
    output logic          busy,
    output logic          done,
    output logic          aborted
);

    state_t        r_state;
    state_t        w_next;
    logic [n-1:0]  r_poly;
    logic [n-1:0]  r_seed;
    logic [CW-1:0] r_count;
    logic          r_w;
    logic [15:0]   r_a;
    logic [n-1:0]  r_d;
    logic          r_out_valid;
    logic [n-1:0]  r_out_data;
    logic          r_busy;
    logic          r_done;
    logic          r_aborted;
    logic          w_accept;
    logic          w_deliver;

    assign cmd_ready = (r_state == IDLE) && !abort;
    assign w_accept  = cmd_valid && cmd_ready;
    assign w_deliver = (r_state == OUTPUT) && out_ready && !abort;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = WR_POLY;
            WR_POLY: w_next = abort ? STOP : WR_SEED;
            WR_SEED: w_next = abort ? STOP : ((r_count == '0) ? DONE : STEP);
            STEP:    w_next = abort ? STOP : SETTLE;
            SETTLE:  w_next = abort ? STOP : OUTPUT;
            OUTPUT: begin
                if (abort)
                    w_next = STOP;
                else if (out_ready)
                    w_next = (r_count <= CW'(1)) ? DONE : STEP;
            end
            STOP:    w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_poly      <= '0;
            r_seed      <= '0;
            r_count     <= '0;
            r_w         <= 1'b0;
            r_a         <= '0;
            r_d         <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_poly  <= cmd_poly;
                r_seed  <= cmd_seed;
                r_count <= cmd_count;
            end
            if (w_deliver && (r_count != '0))
                r_count <= r_count - CW'(1);
            if (r_state == SETTLE)
                r_out_data <= Q;

            r_w <= 1'b0;
            r_a <= '0;
            r_d <= '0;
            case (w_next)
                // WR_POLY is only entered on accept, before r_poly has been loaded
                WR_POLY: begin r_w <= 1'b1; r_a <= POLY_REG; r_d <= cmd_poly;       end
                WR_SEED: begin r_w <= 1'b1; r_a <= LFSR_REG; r_d <= r_seed;         end
                STEP:    begin r_w <= 1'b1; r_a <= CTRL_REG; r_d <= n'(CTRL_STEP); end
                STOP:    begin r_w <= 1'b1; r_a <= CTRL_REG; r_d <= n'(CTRL_STOP); end
                default: ;
            endcase

            r_out_valid <= (w_next == OUTPUT);
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
            r_aborted   <= (w_next == DONE) && (r_state == STOP);
        end
    end

    assign W         = r_w;
    assign A         = r_a;
    assign D         = r_d;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign busy      = r_busy;
    assign done      = r_done;
    assign aborted   = r_aborted;

endmodule

// File: tb/tb_lfsr_step_sequencer.sv
// Scoreboard bench for lfsr_step_sequencer driving a behavioural 8-bit Galois LFSR block.
module tb_lfsr_step_sequencer;

    localparam int N  = 8;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [N-1:0]  cmd_poly = '0;
    logic [N-1:0]  cmd_seed = '0;
    logic [CW-1:0] cmd_count = '0;
    logic          abort = 1'b0;
    logic          W;
    logic [15:0]   A;
    logic [N-1:0]  D;
    logic [N-1:0]  Q;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N-1:0]  out_data;
    logic          busy;
    logic          done;
    logic          aborted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_samples = 0;
    int done_seen = 0;
    int done_cyc = -1;
    int first_valid_cyc = -1;
    logic done_aborted = 1'b0;

    logic [23:0]  exp_bus[$];
    logic [N-1:0] exp_smp[$];
    logic [23:0]  mon_bus;
    logic [N-1:0] mon_smp;

    logic [N-1:0] app_poly = '0;
    logic [N-1:0] app_q = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    lfsr_step_sequencer #(.n(N), .CW(CW)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_poly(cmd_poly), .cmd_seed(cmd_seed), .cmd_count(cmd_count),
        .abort(abort),
        .W(W), .A(A), .D(D), .Q(Q),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .aborted(aborted)
    );

    function automatic logic [N-1:0] lfsr_next(input logic [N-1:0] q, input logic [N-1:0] p);
        return q[0] ? ((q >> 1) ^ p) : (q >> 1);
    endfunction

    // Application LFSR block: not reset by the sequencer
    always @(posedge clock) begin
        if (W) begin
            case (A)
                16'h0010: app_poly <= D;
                16'h0012: app_q    <= D;
                16'h0014: if (D[1:0] == 2'b01) app_q <= lfsr_next(app_q, app_poly);
                default: ;
            endcase
        end
    end
    assign Q = app_q;

    always @(negedge clock) begin
        if (!reset) begin
            if (W) begin
                checks++;
                if (exp_bus.size() == 0) begin
                    errors++;
                    $display("FAIL bus_write unexpected A=%h D=%h at cycle %0d", A, D, cyc);
                end else begin
                    mon_bus = exp_bus.pop_front();
                    if ({A, D} !== mon_bus) begin
                        errors++;
                        $display("FAIL bus_write got A=%h D=%h want A=%h D=%h", A, D,
                                 mon_bus[23:8], mon_bus[7:0]);
                    end
                end
            end else begin
                checks++;
                if (A !== 16'h0 || D !== 8'h0) begin
                    errors++;
                    $display("FAIL bus_idle got A=%h D=%h want 0000/00", A, D);
                end
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready && !abort) begin
                checks++;
                n_samples++;
                if (exp_smp.size() == 0) begin
                    errors++;
                    $display("FAIL sample unexpected got %h", out_data);
                end else begin
                    mon_smp = exp_smp.pop_front();
                    if (out_data !== mon_smp) begin
                        errors++;
                        $display("FAIL sample got %h want %h", out_data, mon_smp);
                    end
                end
            end
            if (done) begin
                done_seen++;
                done_cyc = cyc;
                done_aborted = aborted;
            end
        end
    end

    task automatic push_cmd_exp(input logic [7:0] p, input logic [7:0] s, input int cnt);
        logic [7:0] q;
        exp_bus.push_back({16'h0010, p});
        exp_bus.push_back({16'h0012, s});
        q = s;
        for (int i = 0; i < cnt; i++) begin
            exp_bus.push_back({16'h0014, 8'h01});
            q = lfsr_next(q, p);
            exp_smp.push_back(q);
        end
    endtask

    task automatic issue_cmd(input logic [7:0] p, input logic [7:0] s, input logic [15:0] cnt,
                             output int c);
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_poly = p; cmd_seed = s; cmd_count = cnt;
        c = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            if (cmd_ready) begin c = cyc; break; end
        end
        if (c < 0) begin
            checks++; errors++;
            $display("FAIL cmd_accept got no cmd_ready want accept within 50 cycles");
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        for (int k = 0; k < 200; k++) begin
            @(posedge clock);
            if (done_seen >= target) break;
        end
        checks++;
        if (done_seen < target) begin
            errors++;
            $display("FAIL done_timeout got %0d dones want %0d", done_seen, target);
        end
        #1;
    endtask

    task automatic check_empty(input string tag);
        checks++;
        if (exp_bus.size() != 0 || exp_smp.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got bus=%0d smp=%0d want 0/0", tag, exp_bus.size(),
                     exp_smp.size());
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        checks++;
        if ({W, A, D, out_valid, out_data, busy, done, aborted} !== '0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_values got W=%b A=%h D=%h ov=%b od=%h busy=%b done=%b ab=%b rdy=%b want zeros rdy=1",
                     W, A, D, out_valid, out_data, busy, done, aborted, cmd_ready);
        end
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int c, ns0, ds0;
        out_ready = 1'b1;
        push_cmd_exp(8'hB8, 8'h01, 3);
        ns0 = n_samples; ds0 = done_seen; first_valid_cyc = -1;
        issue_cmd(8'hB8, 8'h01, 16'd3, c);
        wait_done(ds0 + 1);
        checks++;
        if (first_valid_cyc - c !== 5) begin
            errors++; $display("FAIL basic_first_valid got c+%0d want c+5", first_valid_cyc - c);
        end
        checks++;
        if (done_cyc - c !== 12 || done_aborted !== 1'b0) begin
            errors++; $display("FAIL basic_done got c+%0d ab=%b want c+12 ab=0", done_cyc - c, done_aborted);
        end
        checks++;
        if (n_samples - ns0 !== 3) begin
            errors++; $display("FAIL basic_samples got %0d want 3", n_samples - ns0);
        end
        check_empty("basic");
    endtask

    task automatic test_zero_count();
        int c, ds0;
        push_cmd_exp(8'h8E, 8'h33, 0);
        ds0 = done_seen; first_valid_cyc = -1;
        issue_cmd(8'h8E, 8'h33, 16'd0, c);
        wait_done(ds0 + 1);
        checks++;
        if (done_cyc - c !== 3 || first_valid_cyc !== -1) begin
            errors++; $display("FAIL zero_done got c+%0d valid_at=%0d want c+3 valid_at=-1",
                               done_cyc - c, first_valid_cyc);
        end
        check_empty("zero");
    endtask

    task automatic test_backpressure();
        int c, ds0, ns0;
        logic [7:0] d0;
        out_ready = 1'b0;
        push_cmd_exp(8'hB4, 8'hA5, 2);
        ds0 = done_seen; ns0 = n_samples;
        issue_cmd(8'hB4, 8'hA5, 16'd2, c);
        for (int k = 0; k < 20; k++) begin
            @(negedge clock);
            if (out_valid) break;
        end
        d0 = out_data;
        checks++;
        if (out_valid !== 1'b1 || d0 !== lfsr_next(8'hA5, 8'hB4)) begin
            errors++; $display("FAIL bp_first got ov=%b %h want ov=1 %h", out_valid, d0,
                               lfsr_next(8'hA5, 8'hB4));
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b1 || out_data !== d0 || W !== 1'b0) begin
                errors++; $display("FAIL bp_hold got ov=%b %h W=%b want ov=1 %h W=0",
                                   out_valid, out_data, W, d0);
            end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
        wait_done(ds0 + 1);
        checks++;
        if (n_samples - ns0 !== 2) begin
            errors++; $display("FAIL bp_samples got %0d want 2", n_samples - ns0);
        end
        check_empty("bp");
    endtask

    task automatic test_abort();
        int c, ds0, ns0;
        cmd_valid = 1'b1; abort = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (cmd_ready !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL abort_idle got rdy=%b busy=%b want 0/0", cmd_ready, busy);
            end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0; abort = 1'b0;
        out_ready = 1'b1;
        exp_bus.push_back({16'h0010, 8'hB8});
        exp_bus.push_back({16'h0012, 8'hC3});
        exp_bus.push_back({16'h0014, 8'h01});
        exp_bus.push_back({16'h0014, 8'h01});
        exp_bus.push_back({16'h0014, 8'h00});
        exp_smp.push_back(lfsr_next(8'hC3, 8'hB8));
        ds0 = done_seen; ns0 = n_samples;
        issue_cmd(8'hB8, 8'hC3, 16'd4, c);
        while (cyc < c + 8) begin @(posedge clock); #1; end
        abort = 1'b1;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++; $display("FAIL abort_sample2_offered got ov=%b want 1", out_valid);
        end
        @(posedge clock); #1;
        abort = 1'b0;
        wait_done(ds0 + 1);
        checks++;
        if (done_cyc - c !== 10 || done_aborted !== 1'b1) begin
            errors++; $display("FAIL abort_done got c+%0d ab=%b want c+10 ab=1", done_cyc - c, done_aborted);
        end
        checks++;
        if (n_samples - ns0 !== 1) begin
            errors++; $display("FAIL abort_samples got %0d want 1", n_samples - ns0);
        end
        check_empty("abort");
    endtask

    task automatic test_reset_mid();
        int c, ds0, ns0;
        push_cmd_exp(8'hB8, 8'h01, 3);
        issue_cmd(8'hB8, 8'h01, 16'd3, c);
        while (cyc < c + 3) begin @(posedge clock); #1; end
        checks++;
        if (W !== 1'b1 || A !== 16'h0014 || busy !== 1'b1) begin
            errors++; $display("FAIL rst_pre_step got W=%b A=%h busy=%b want 1/0014/1", W, A, busy);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (W !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0 || A !== 16'h0) begin
            errors++; $display("FAIL rst_async got W=%b ov=%b busy=%b A=%h want 0/0/0/0000",
                               W, out_valid, busy, A);
        end
        exp_bus.delete();
        exp_smp.delete();
        @(posedge clock); #1;
        reset = 1'b0;
        push_cmd_exp(8'h8E, 8'h5A, 2);
        ds0 = done_seen; ns0 = n_samples; first_valid_cyc = -1;
        issue_cmd(8'h8E, 8'h5A, 16'd2, c);
        wait_done(ds0 + 1);
        checks++;
        if (done_cyc - c !== 9 || first_valid_cyc - c !== 5 || n_samples - ns0 !== 2) begin
            errors++; $display("FAIL rst_rerun got done=c+%0d valid=c+%0d smp=%0d want c+9 c+5 2",
                               done_cyc - c, first_valid_cyc - c, n_samples - ns0);
        end
        check_empty("rst");
    endtask

    task automatic test_back_to_back();
        int acc, viol, ds0;
        int acc_c[2];
        acc = 0; viol = 0; ds0 = done_seen;
        acc_c[0] = -1; acc_c[1] = -1;
        out_ready = 1'b1;
        push_cmd_exp(8'hB8, 8'h11, 1);
        push_cmd_exp(8'hE1, 8'h7F, 1);
        @(posedge clock); #1;
        cmd_valid = 1'b1; cmd_poly = 8'hB8; cmd_seed = 8'h11; cmd_count = 16'd1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            if (busy && cmd_ready) viol++;
            if (cmd_ready) begin acc_c[acc] = cyc; acc++; end
            if (acc == 2) break;
            @(posedge clock); #1;
            if (acc == 1) begin cmd_poly = 8'hE1; cmd_seed = 8'h7F; end
        end
        @(posedge clock); #1;
        cmd_valid = 1'b0;
        wait_done(ds0 + 2);
        checks++;
        if (acc !== 2 || acc_c[1] - acc_c[0] !== 7 || viol !== 0) begin
            errors++; $display("FAIL b2b got acc=%0d gap=%0d viol=%0d want 2 7 0",
                               acc, acc_c[1] - acc_c[0], viol);
        end
        check_empty("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish before 200000");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_zero_count();
        test_backpressure();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(posedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
